// File: rtl/sort_result_reader.sv
// sort_result_reader
//   Reads the DEPTH result words out of the heap-sort result RAM once the
//   sorter reports done. Each word goes out on a valid/ready stream, lowest
//   address first. The data is checked for monotonic order in the ASCEND
//   direction, and the first address that breaks the order is recorded.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   sort_done  level from the sorter; high means the RAM contents are final
//   IRAM_rd    RAM read strobe
//   IRAM_A     RAM read address
//   IRAM_Q     RAM read data, valid the cycle after IRAM_rd
//   out_valid  out_data holds a word
//   out_ready  consumer accepts the word
//   out_data   word read from the RAM
//   out_last   marks the word from address DEPTH-1
//   busy       readout in progress
//   finished   readout complete (held until sort_done drops)
//   order_err  sticky order-violation flag for the current readout
//   err_addr   address of the first violating word
module sort_result_reader #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int ASCEND = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sort_done,
  output logic          IRAM_rd,
  output logic [AW-1:0] IRAM_A,
  input  logic [DW-1:0] IRAM_Q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          finished,
  output logic          order_err,
  output logic [AW-1:0] err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_HOLD,
    S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [DW-1:0] prev, prev_nx;

  logic          iram_rd_nx;
  logic [AW-1:0] iram_a_nx;
  logic          out_valid_nx;
  logic [DW-1:0] out_data_nx;
  logic          out_last_nx;
  logic          busy_nx;
  logic          finished_nx;
  logic          order_err_nx;
  logic [AW-1:0] err_addr_nx;

  logic          violation;

  // Equal neighbours are never a violation in either direction.
  always_comb begin
    if (ASCEND != 0) violation = (IRAM_Q < prev);
    else             violation = (IRAM_Q > prev);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      prev      <= '0;
      IRAM_rd   <= 1'b0;
      IRAM_A    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      order_err <= 1'b0;
      err_addr  <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      prev      <= prev_nx;
      IRAM_rd   <= iram_rd_nx;
      IRAM_A    <= iram_a_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_last  <= out_last_nx;
      busy      <= busy_nx;
      finished  <= finished_nx;
      order_err <= order_err_nx;
      err_addr  <= err_addr_nx;
    end
  end

  // Outputs are registered, so each transition computes the value the
  // outputs must carry in the *next* state (e.g. IRAM_rd is raised on the
  // edge that enters REQ and dropped on the edge that leaves it).
  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    prev_nx      = prev;
    iram_rd_nx   = 1'b0;
    iram_a_nx    = IRAM_A;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_last_nx  = out_last;
    busy_nx      = busy;
    finished_nx  = finished;
    order_err_nx = order_err;
    err_addr_nx  = err_addr;

    case (state)
      S_IDLE: begin
        if (sort_done && !finished) begin
          state_nx     = S_REQ;
          busy_nx      = 1'b1;
          addr_nx      = '0;
          order_err_nx = 1'b0;
          err_addr_nx  = '0;
          iram_rd_nx   = 1'b1;
          iram_a_nx    = '0;
        end
      end

      S_REQ: begin
        state_nx = S_CAPT;
      end

      S_CAPT: begin
        out_data_nx  = IRAM_Q;
        out_valid_nx = 1'b1;
        out_last_nx  = (addr == LAST_ADDR);
        if ((addr != '0) && violation && !order_err) begin
          order_err_nx = 1'b1;
          err_addr_nx  = addr;
        end
        prev_nx  = IRAM_Q;
        state_nx = S_HOLD;
      end

      S_HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_nx = 1'b0;
          out_last_nx  = 1'b0;
          if (addr == LAST_ADDR) begin
            state_nx    = S_FIN;
            busy_nx     = 1'b0;
            finished_nx = 1'b1;
          end else begin
            addr_nx    = addr + AW'(1);
            iram_a_nx  = addr + AW'(1);
            iram_rd_nx = 1'b1;
            state_nx   = S_REQ;
          end
        end
      end

      S_FIN: begin
        if (!sort_done) begin
          finished_nx = 1'b0;
          state_nx    = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
